// File: rtl/fan_deg_tick_gen_if.sv
// ---------------------------------------------------------------------------
// fan_deg_tick_gen_if
// Groups the hall-sensor input and the degree-tick / status outputs of the
// fan degree tick generator.
//   hall      : raw hall sensor level, high near the index mark
//   fanclk    : one-cycle degree tick
//   rev_start : one-cycle pulse on each accepted index edge
//   locked    : high while the generator is tracking the revolution
//   period    : last valid revolution period in clk cycles
//   slip      : one-cycle pulse when an index arrives before all ticks were due
// Modports:
//   master : the side that owns the sensor and consumes the ticks
//   slave  : the tick generator itself
// ---------------------------------------------------------------------------
interface fan_deg_tick_gen_if #(
    parameter int PER_W = 24
);
    logic             hall;
    logic             fanclk;
    logic             rev_start;
    logic             locked;
    logic [PER_W-1:0] period;
    logic             slip;

    modport master (
        output hall,
        input  fanclk,
        input  rev_start,
        input  locked,
        input  period,
        input  slip
    );

    modport slave (
        input  hall,
        output fanclk,
        output rev_start,
        output locked,
        output period,
        output slip
    );
endinterface

// File: rtl/fan_deg_tick_gen.sv
// ---------------------------------------------------------------------------
// fan_deg_tick_gen
// Converts the once-per-revolution hall index into DEG_STEPS evenly spread
// single-cycle degree ticks. The revolution period is measured in clk cycles
// and the ticks are placed with a remainder accumulator (acc += DEG_STEPS,
// subtract the period on overflow), so no divider is needed.
// Ports:
//   clk   : system clock
//   rst   : asynchronous reset, active low
//   bus   : slave side of fan_deg_tick_gen_if (hall in; fanclk, rev_start,
//           locked, period, slip out -- all registered)
// ---------------------------------------------------------------------------
module fan_deg_tick_gen #(
    parameter int PER_W      = 24,
    parameter int DEG_STEPS  = 360,
    parameter int DEB_CYC    = 16,
    parameter int MIN_PERIOD = 2000,
    parameter int MAX_PERIOD = (1 << PER_W) - 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fan_deg_tick_gen_if.slave    bus
);

    localparam int TICK_W = $clog2(DEG_STEPS);
    localparam int DEB_W  = $clog2(DEB_CYC + 1);

    localparam logic [PER_W:0]    STEP_C      = (PER_W+1)'(DEG_STEPS);
    localparam logic [PER_W-1:0]  MIN_C       = PER_W'(MIN_PERIOD);
    localparam logic [PER_W-1:0]  MAX_C       = PER_W'(MAX_PERIOD);
    localparam logic [PER_W-1:0]  SAT_C       = {PER_W{1'b1}};
    localparam logic [PER_W-1:0]  PER_ONE_C   = PER_W'(1);
    localparam logic [TICK_W-1:0] TICK_LAST_C = TICK_W'(DEG_STEPS - 1);
    localparam logic [TICK_W-1:0] TICK_ONE_C  = TICK_W'(1);
    localparam logic [DEB_W-1:0]  DEB_LAST_C  = DEB_W'(DEB_CYC - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE_C   = DEB_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        RUN  = 2'd2
    } state_t;

    logic              sync1_r;
    logic              sync2_r;
    logic              deb_level_r;
    logic [DEB_W-1:0]  deb_cnt_r;
    logic              index_r;
    logic [PER_W-1:0]  per_cnt_r;

    state_t            state_r;
    state_t            state_next_s;
    logic [PER_W:0]    acc_r;
    logic [PER_W:0]    acc_next_s;
    logic [TICK_W-1:0] tick_cnt_r;
    logic [TICK_W-1:0] tick_next_s;
    logic [PER_W-1:0]  period_r;
    logic [PER_W-1:0]  period_next_s;
    logic              fanclk_r;
    logic              fanclk_next_s;
    logic              slip_r;
    logic              slip_next_s;
    logic              locked_r;

    logic              valid_s;
    logic              timeout_s;
    logic [PER_W:0]    sum_s;
    logic              wrap_s;

    // Hall synchronizer, debounce filter, index detection and period counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r     <= 1'b0;
            sync2_r     <= 1'b0;
            deb_level_r <= 1'b0;
            deb_cnt_r   <= '0;
            index_r     <= 1'b0;
            per_cnt_r   <= '0;
        end else begin
            sync1_r <= bus.hall;
            sync2_r <= sync1_r;
            // The level only flips after DEB_CYC consecutive disagreeing
            // samples; the index fires in the cycle the new high level lands.
            if (sync2_r != deb_level_r) begin
                if (deb_cnt_r == DEB_LAST_C) begin
                    deb_level_r <= sync2_r;
                    deb_cnt_r   <= '0;
                    index_r     <= sync2_r;
                end else begin
                    deb_cnt_r   <= deb_cnt_r + DEB_ONE_C;
                    index_r     <= 1'b0;
                end
            end else begin
                deb_cnt_r <= '0;
                index_r   <= 1'b0;
            end
            // Restarting at 1 makes the value seen at the next index equal to
            // the number of cycles between the two index events.
            if (index_r) begin
                per_cnt_r <= PER_ONE_C;
            end else if (per_cnt_r != SAT_C) begin
                per_cnt_r <= per_cnt_r + PER_ONE_C;
            end else begin
                per_cnt_r <= per_cnt_r;
            end
        end
    end

    assign valid_s   = (per_cnt_r >= MIN_C) && (per_cnt_r <= MAX_C);
    assign timeout_s = (per_cnt_r >= MAX_C);
    assign sum_s     = acc_r + STEP_C;
    assign wrap_s    = (sum_s >= {1'b0, period_r});

    // Next-state and datapath decisions; an index always outranks a timeout.
    always_comb begin
        state_next_s  = state_r;
        acc_next_s    = acc_r;
        tick_next_s   = tick_cnt_r;
        period_next_s = period_r;
        fanclk_next_s = 1'b0;
        slip_next_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (index_r) begin
                    state_next_s = ACQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACQ: begin
                if (index_r) begin
                    if (valid_s) begin
                        state_next_s  = RUN;
                        period_next_s = per_cnt_r;
                        acc_next_s    = '0;
                        tick_next_s   = '0;
                    end else begin
                        state_next_s = ACQ;
                    end
                end else if (timeout_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = ACQ;
                end
            end
            RUN: begin
                if (index_r) begin
                    if (valid_s) begin
                        // Wrap tick replaces any accumulator tick due now;
                        // ticks still owed from this revolution are dropped.
                        state_next_s  = RUN;
                        fanclk_next_s = 1'b1;
                        slip_next_s   = (tick_cnt_r < TICK_LAST_C);
                        period_next_s = per_cnt_r;
                        acc_next_s    = '0;
                        tick_next_s   = '0;
                    end else begin
                        state_next_s = ACQ;
                    end
                end else if (timeout_s) begin
                    state_next_s = IDLE;
                end else if (wrap_s) begin
                    acc_next_s = sum_s - {1'b0, period_r};
                    // The last tick of a revolution is reserved for the index.
                    if (tick_cnt_r < TICK_LAST_C) begin
                        fanclk_next_s = 1'b1;
                        tick_next_s   = tick_cnt_r + TICK_ONE_C;
                    end else begin
                        tick_next_s = tick_cnt_r;
                    end
                end else begin
                    acc_next_s = sum_s;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state, accumulator and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            acc_r      <= '0;
            tick_cnt_r <= '0;
            period_r   <= '0;
            fanclk_r   <= 1'b0;
            slip_r     <= 1'b0;
            locked_r   <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            acc_r      <= acc_next_s;
            tick_cnt_r <= tick_next_s;
            period_r   <= period_next_s;
            fanclk_r   <= fanclk_next_s;
            slip_r     <= slip_next_s;
            locked_r   <= (state_next_s == RUN);
        end
    end

    assign bus.fanclk    = fanclk_r;
    assign bus.rev_start = index_r;
    assign bus.locked    = locked_r;
    assign bus.period    = period_r;
    assign bus.slip      = slip_r;

endmodule

// File: tb/tb_fan_deg_tick_gen.sv
// ---------------------------------------------------------------------------
// tb_fan_deg_tick_gen
// Scaled-down instance (36 ticks/rev, 12-bit period, MIN 200, MAX 4094,
// 4-cycle debounce) so that timeouts fit in a short run. Each table record
// describes one index: cycles since the previous hall rise, pulse width,
// optional glitch, and the expected status after that index plus the tick
// statistics of the revolution it closes.
// ---------------------------------------------------------------------------
module tb_fan_deg_tick_gen;

    localparam int PER_W = 12;

    typedef struct {
        int gap;
        int hi_len;
        int glitch;
        int exp_locked;
        int exp_period;
        int exp_ticks;
        int exp_slip;
        int exp_min;
        int exp_max;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks = 0;
    int errors = 0;

    fan_deg_tick_gen_if #(.PER_W(PER_W)) bus ();

    fan_deg_tick_gen #(
        .PER_W      (PER_W),
        .DEG_STEPS  (36),
        .DEB_CYC    (4),
        .MIN_PERIOD (200),
        .MAX_PERIOD (4094)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Monitor: per-revolution tick statistics, windows close one cycle after
    // rev_start so the wrap tick belongs to the revolution it ends.
    int   cyc        = 0;
    int   cur_cnt    = 0;
    int   cur_min    = -1;
    int   cur_max    = -1;
    int   last_tick  = -1;
    int   win_cnt    = 0;
    int   win_min    = -1;
    int   win_max    = -1;
    int   rs_total   = 0;
    int   slip_total = 0;
    int   tick_total = 0;
    logic rs_q       = 1'b0;

    always @(negedge clk) begin
        int g;
        int nc;
        int nmin;
        int nmax;
        int nlast;
        nc    = cur_cnt;
        nmin  = cur_min;
        nmax  = cur_max;
        nlast = last_tick;
        cyc        <= cyc + 1;
        rs_q       <= bus.rev_start;
        rs_total   <= rs_total + int'(bus.rev_start);
        slip_total <= slip_total + int'(bus.slip);
        tick_total <= tick_total + int'(bus.fanclk);
        if (!rst) begin
            nc = 0; nmin = -1; nmax = -1; nlast = -1;
        end else begin
            if (bus.fanclk) begin
                nc = nc + 1;
                if (nlast >= 0) begin
                    g = cyc - nlast;
                    if (nmin < 0 || g < nmin) nmin = g;
                    if (g > nmax) nmax = g;
                end
                nlast = cyc;
            end
            if (!bus.locked) nlast = -1;
            if (rs_q) begin
                win_cnt <= nc;
                win_min <= nmin;
                win_max <= nmax;
                nc = 0; nmin = -1; nmax = -1;
            end
        end
        cur_cnt   <= nc;
        cur_min   <= nmin;
        cur_max   <= nmax;
        last_tick <= nlast;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Drive one index (hall rises v.gap cycles after the previous rise) and
    // check status 10 cycles after the rise.
    task automatic do_index(input vec_t v, input int id);
        int low_len;
        int rs_snap;
        int slip_snap;
        low_len   = v.gap - 20;
        rs_snap   = rs_total;
        slip_snap = slip_total;
        for (int i = 0; i < low_len; i++) begin
            bus.hall = (v.glitch > 0) && (i >= low_len / 2) && (i < low_len / 2 + v.glitch);
            @(negedge clk);
        end
        for (int i = 0; i < 20; i++) begin
            bus.hall = (i < v.hi_len);
            if (i == 10) begin
                chk($sformatf("v%0d_rev_start", id), rs_total - rs_snap, 1);
                chk($sformatf("v%0d_slip", id), slip_total - slip_snap, v.exp_slip);
                chk($sformatf("v%0d_locked", id), int'(bus.locked), v.exp_locked);
                chk($sformatf("v%0d_period", id), int'(bus.period), v.exp_period);
                chk($sformatf("v%0d_ticks", id), win_cnt, v.exp_ticks);
                if (v.exp_min >= 0) begin
                    chk($sformatf("v%0d_min_gap", id), win_min, v.exp_min);
                    chk($sformatf("v%0d_max_gap", id), win_max, v.exp_max);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        int   tick_snap;
        //            gap  hi gl lk period tk sl min max
        tbl[0]  = '{ 100, 20, 0, 0,    0,  0, 0,  -1,  -1};
        tbl[1]  = '{3600, 20, 0, 1, 3600,  0, 0,  -1,  -1};
        tbl[2]  = '{3600, 20, 0, 1, 3600, 36, 0, 100, 100};
        tbl[3]  = '{3600, 20, 1, 1, 3600, 36, 0, 100, 100};
        tbl[4]  = '{3610, 20, 0, 1, 3610, 36, 0, 100, 110};
        tbl[5]  = '{3610, 20, 2, 1, 3610, 36, 0, 100, 101};
        tbl[6]  = '{3600, 20, 0, 1, 3600, 36, 0,  90, 101};
        tbl[7]  = '{3000, 20, 0, 1, 3000, 30, 1, 100, 100};
        tbl[8]  = '{3000, 20, 3, 1, 3000, 36, 0,  83,  84};
        tbl[9]  = '{ 150, 20, 0, 0, 3000,  1, 0,  84,  84};
        tbl[10] = '{3600, 20, 0, 1, 3600,  0, 0,  -1,  -1};
        tbl[11] = '{3600,  5, 0, 1, 3600, 36, 0, 100, 100};

        bus.hall = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_fanclk", int'(bus.fanclk), 0);
        chk("rst_rev_start", int'(bus.rev_start), 0);
        chk("rst_locked", int'(bus.locked), 0);
        chk("rst_period", int'(bus.period), 0);
        chk("rst_slip", int'(bus.slip), 0);
        rst = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 12; k++) begin
            do_index(tbl[k], k);
        end

        // Hall stops: lock must hold until the counter hits MAX_PERIOD.
        repeat (3940) @(negedge clk);
        chk("to_locked_before", int'(bus.locked), 1);
        tick_snap = tick_total;
        repeat (200) @(negedge clk);
        chk("to_locked_after", int'(bus.locked), 0);
        chk("to_period_hold", int'(bus.period), 3600);
        chk("to_no_ticks", tick_total - tick_snap, 0);
        do_index('{ 100, 20, 0, 0, 3600, 35, 0, 100, 100}, 20);
        do_index('{3600, 20, 0, 1, 3600,  0, 0,  -1,  -1}, 21);
        do_index('{3600, 20, 0, 1, 3600, 36, 0, 100, 100}, 22);

        // Asynchronous reset between clock edges while running.
        repeat (1000) @(negedge clk);
        chk("pre_rst_locked", int'(bus.locked), 1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_fanclk", int'(bus.fanclk), 0);
        chk("arst_rev_start", int'(bus.rev_start), 0);
        chk("arst_locked", int'(bus.locked), 0);
        chk("arst_period", int'(bus.period), 0);
        chk("arst_slip", int'(bus.slip), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        do_index('{ 100, 20, 0, 0,    0,  0, 0,  -1,  -1}, 30);
        do_index('{ 150, 20, 0, 0,    0,  0, 0,  -1,  -1}, 31);
        do_index('{3600, 20, 0, 1, 3600,  0, 0,  -1,  -1}, 32);
        do_index('{3600, 20, 0, 1, 3600, 36, 0, 100, 100}, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
